pc_stack: RTL and testbench

- Program counter and hardware return stack for the baseline-style core.
- Sits downstream of the register file and consumes its page_out (STATUS[6:5], PA1:PA0) to form GOTO, CALL and PCL-write targets.
- Drives the fetch address to program ROM.
- Tells the fetch/decode stage when the prefetched instruction must be discarded.
- Provides PC[7:0] for reads of file address 0x02 (PCL).

---
 rtl/pc_stack.sv | 87 ++++++++
 tb/tb_pc_stack.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// Program counter and shift-register return stack for a baseline-style core.
// Forms GOTO/CALL/PCL-write targets from the page bits and flags control transfers.
module pc_stack #(
  parameter int unsigned      PC_WIDTH     = 11,
  parameter int unsigned      STACK_DEPTH  = 2,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(11'h7FF)
) (
  input  logic                               clk_in,
  input  logic                               reset_in,
  input  logic                               cycle_en_in,
  input  logic [1:0]                         page_in,
  input  logic                               goto_in,
  input  logic                               call_in,
  input  logic                               ret_in,
  input  logic                               pcl_write_in,
  input  logic [7:0]                         pcl_d_in,
  input  logic                               skip_in,
  input  logic [8:0]                         k_in,
  output logic [PC_WIDTH-1:0]                pc_out,
  output logic [7:0]                         pcl_out,
  output logic                               flush_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level_out,
  output logic                               overflow_out,
  output logic                               underflow_out
);

  localparam int unsigned LW = $clog2(STACK_DEPTH + 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
  logic [LW-1:0]       level;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] goto_target;
  logic [PC_WIDTH-1:0] call_target;
  logic [PC_WIDTH-1:0] pcl_target;

  // Targets are built at the native 11-bit width, then zero-extended or truncated.
  assign pc_inc      = pc + PC_WIDTH'(1);
  assign goto_target = PC_WIDTH'({page_in, k_in});
  assign call_target = PC_WIDTH'({page_in, 1'b0, k_in[7:0]});
  assign pcl_target  = PC_WIDTH'({page_in, 1'b0, pcl_d_in});

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      pc            <= RESET_VECTOR;
      level         <= '0;
      flush_out     <= 1'b0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
      // NOTE: the stack is a small register array, so clearing it in reset is cheap and makes a RETLW-before-CALL deterministic.
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      flush_out <= 1'b0;
      if (cycle_en_in) begin
        flush_out <= 1'b1;
        if (goto_in) begin
          pc <= goto_target;
        end else if (call_in) begin
          stack[0] <= pc_inc;
          for (int i = 1; i < STACK_DEPTH; i++) stack[i] <= stack[i-1];
          if (level == LEVEL_FULL) overflow_out <= 1'b1;
          else                     level        <= level + LW'(1);
          pc <= call_target;
        end else if (ret_in) begin
          // Bottom entry is not written, so it is duplicated upward on each pop.
          for (int i = 1; i < STACK_DEPTH; i++) stack[i-1] <= stack[i];
          if (level == '0) underflow_out <= 1'b1;
          else             level         <= level - LW'(1);
          pc <= stack[0];
        end else if (pcl_write_in) begin
          pc <= pcl_target;
        end else if (skip_in) begin
          pc <= pc_inc;
        end else begin
          pc        <= pc_inc;
          flush_out <= 1'b0;
        end
      end
    end
  end

  assign pc_out          = pc;
  assign pcl_out         = 8'(pc);
  assign stack_level_out = level;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed vector table, hand-written corner
// sequences, and randomized stimulus against a queue-based reference model.
module tb_pc_stack;

  localparam int PCW   = 11;
  localparam int DEPTH = 2;
  localparam int MASK  = (1 << PCW) - 1;

  logic           clk_in = 1'b0;
  logic           reset_in, cycle_en_in, goto_in, call_in, ret_in, pcl_write_in, skip_in;
  logic [1:0]     page_in;
  logic [7:0]     pcl_d_in;
  logic [8:0]     k_in;
  logic [PCW-1:0] pc_out;
  logic [7:0]     pcl_out;
  logic           flush_out, overflow_out, underflow_out;
  logic [1:0]     stack_level_out;

  pc_stack dut (
    .clk_in(clk_in), .reset_in(reset_in), .cycle_en_in(cycle_en_in),
    .page_in(page_in), .goto_in(goto_in), .call_in(call_in), .ret_in(ret_in),
    .pcl_write_in(pcl_write_in), .pcl_d_in(pcl_d_in), .skip_in(skip_in), .k_in(k_in),
    .pc_out(pc_out), .pcl_out(pcl_out), .flush_out(flush_out),
    .stack_level_out(stack_level_out), .overflow_out(overflow_out),
    .underflow_out(underflow_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit       rst, en, gt, cl, rt, pw, sk;
    bit [1:0] page;
    bit [8:0] k;
    bit [7:0] d;
    int       e_pc;
    bit       e_flush;
    int       e_lvl;
    bit       e_ov, e_un;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_pc, m_lvl;
  bit m_flush, m_ov, m_un;
  int m_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input vec_t v);
    int bottom;
    if (v.rst) begin
      m_pc = 'h7FF; m_lvl = 0; m_flush = 0; m_ov = 0; m_un = 0;
      m_q.delete();
      for (int i = 0; i < DEPTH; i++) m_q.push_back(0);
    end else if (!v.en) begin
      m_flush = 0;
    end else begin
      m_flush = 1;
      if (v.gt) begin
        m_pc = ((v.page << 9) | v.k) & MASK;
      end else if (v.cl) begin
        m_q.push_front((m_pc + 1) & MASK);
        void'(m_q.pop_back());
        if (m_lvl == DEPTH) m_ov = 1; else m_lvl++;
        m_pc = ((v.page << 9) | (v.k & 'hFF)) & MASK;
      end else if (v.rt) begin
        bottom = m_q[$];
        m_pc = m_q.pop_front();
        m_q.push_back(bottom);
        if (m_lvl == 0) m_un = 1; else m_lvl--;
      end else if (v.pw) begin
        m_pc = ((v.page << 9) | v.d) & MASK;
      end else begin
        m_pc = (m_pc + 1) & MASK;
        if (!v.sk) m_flush = 0;
      end
    end
  endtask

  task automatic apply(input vec_t v);
    reset_in = v.rst; cycle_en_in = v.en; goto_in = v.gt; call_in = v.cl;
    ret_in = v.rt; pcl_write_in = v.pw; skip_in = v.sk; page_in = v.page;
    k_in = v.k; pcl_d_in = v.d;
    @(posedge clk_in);
    #1;
    model_step(v);
  endtask

  function automatic vec_t mk(bit rst, bit en, bit gt, bit cl, bit rt, bit pw, bit sk,
                              bit [1:0] page, bit [8:0] k, bit [7:0] d,
                              int e_pc, bit e_flush, int e_lvl, bit e_ov, bit e_un);
    vec_t v;
    v.rst = rst; v.en = en; v.gt = gt; v.cl = cl; v.rt = rt; v.pw = pw; v.sk = sk;
    v.page = page; v.k = k; v.d = d;
    v.e_pc = e_pc; v.e_flush = e_flush; v.e_lvl = e_lvl; v.e_ov = e_ov; v.e_un = e_un;
    return v;
  endfunction

  task automatic check_all(input string tag, input int pc, input bit fl, input int lvl,
                           input bit ov, input bit un);
    check({tag, ".pc"},    int'(pc_out),          pc);
    check({tag, ".pcl"},   int'(pcl_out),         pc & 'hFF);
    check({tag, ".flush"}, int'(flush_out),       int'(fl));
    check({tag, ".level"}, int'(stack_level_out), lvl);
    check({tag, ".ovf"},   int'(overflow_out),    int'(ov));
    check({tag, ".unf"},   int'(underflow_out),   int'(un));
  endtask

  vec_t tbl[$];

  initial begin
    //             rst en gt cl rt pw sk page  k       d      pc     fl lvl ov un
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 9'h000, 8'h00, 'h7FF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2'd0, 9'h000, 8'h00, 'h000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2'd0, 9'h000, 8'h00, 'h001, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2'd0, 9'h000, 8'h00, 'h002, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2'd2, 9'h1A5, 8'h00, 'h5A5, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2'd0, 9'h000, 8'h00, 'h5A6, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2'd0, 9'h010, 8'h00, 'h010, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2'd1, 9'h1C3, 8'h00, 'h2C3, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 2'd0, 9'h000, 8'h00, 'h011, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2'd0, 9'h000, 8'h00, 'h012, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2'd0, 9'h010, 8'h00, 'h010, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2'd0, 9'h100, 8'h00, 'h000, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2'd0, 9'h101, 8'h00, 'h101, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2'd0, 9'h200, 8'h00, 'h000, 1, 2, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2'd1, 9'h002, 8'h00, 'h202, 1, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2'd0, 9'h080, 8'h00, 'h080, 1, 2, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 2'd0, 9'h000, 8'h00, 'h203, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 2'd0, 9'h000, 8'h00, 'h102, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 2'd0, 9'h000, 8'h00, 'h102, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 2'd0, 9'h055, 8'h00, 'h055, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 2'd3, 9'h000, 8'h7E, 'h67E, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2'd0, 9'h000, 8'h00, 'h67E, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 2'd1, 9'h0FF, 8'h00, 'h7FF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 2'd0, 9'h000, 8'h00, 'h000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2'd0, 9'h000, 8'h00, 'h001, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 2'd2, 9'h000, 8'h33, 'h000, 1, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_flush, tbl[i].e_lvl,
                tbl[i].e_ov, tbl[i].e_un);
    end

    // Hand sequence: goto to the top word, increment wraps, flush drops when enable is low.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 9'h000, 8'h00, 0, 0, 0, 0, 0));
    apply(mk(0, 1, 1, 0, 0, 0, 0, 2'd3, 9'h1FF, 8'h00, 0, 0, 0, 0, 0));
    check_all("seq_goto_top", 'h7FF, 1, 0, 0, 0);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 9'h000, 8'h00, 0, 0, 0, 0, 0));
    check_all("seq_hold", 'h7FF, 0, 0, 0, 0);
    apply(mk(0, 1, 0, 0, 0, 0, 0, 2'd0, 9'h000, 8'h00, 0, 0, 0, 0, 0));
    check_all("seq_wrap", 'h000, 0, 0, 0, 0);
    // Call from the top word: the return address wraps to zero.
    apply(mk(0, 1, 1, 0, 0, 0, 0, 2'd3, 9'h1FF, 8'h00, 0, 0, 0, 0, 0));
    apply(mk(0, 1, 0, 1, 0, 0, 0, 2'd0, 9'h1AA, 8'h00, 0, 0, 0, 0, 0));
    check_all("seq_call_top", 'h0AA, 1, 1, 0, 0);
    apply(mk(0, 1, 0, 0, 1, 0, 0, 2'd0, 9'h000, 8'h00, 0, 0, 0, 0, 0));
    check_all("seq_ret_wrap", 'h000, 1, 0, 0, 0);

    // Randomized phase against the reference model.
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      v = mk($urandom_range(0, 63) == 0, $urandom_range(0, 4) != 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 5) == 0, 2'($urandom), 9'($urandom), 8'($urandom),
             0, 0, 0, 0, 0);
      apply(v);
      check_all("rand", m_pc, m_flush, m_lvl, m_ov, m_un);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
